knn_dma_mm2s_burst_engine: RTL and testbench
============================================

Name: knn_dma_mm2s_burst_engine

Overview:
Parametrised AXI4 read master (MM2S) for the KNN DMA. Splits a beat-counted transfer into INCR bursts that never cross a 4 KB boundary and keeps up to C_MAX_OUTSTANDING bursts in flight. Read data is buffered in an internal FIFO with credit reservation and delivered on a valid/ready stream with a last flag. It sits between the DMA control registers and the KNN compute datapath, and replaces the fixed wr_en/data_out read master.

Parameters:
C_M_AXI_BURST_LEN, 256, max beats per burst (1..256)
C_M_AXI_ID_WIDTH, 1, ARID/RID width
C_M_AXI_ADDR_WIDTH, 32, address width
C_M_AXI_DATA_WIDTH, 64, data width (32/64/128/256)
C_M_AXI_ARUSER_WIDTH, 1, ARUSER width
C_M_AXI_RUSER_WIDTH, 1, RUSER width
C_MAX_OUTSTANDING, 4, max AR-issued bursts with R not yet complete (1..16)
C_FIFO_DEPTH, 512, output FIFO depth in beats (power of 2, >= C_M_AXI_BURST_LEN)

Ports:
M_AXI_ACLK  in  1  clock; the only clock
M_AXI_ARESET  in  1  reset, synchronous, active-high
start  in  1  one-cycle start pulse; ignored while busy
starting_addr  in  ADDR_WIDTH  byte address; low log2(DATA_WIDTH/8) bits forced to 0
starting_length  in  32  transfer length in beats
busy  out  1  transfer active
transfer_done  out  1  one-cycle pulse at transfer end
error  out  1  sticky: non-OKAY RRESP seen in current/last transfer
out_valid  out  1  stream data valid
out_data  out  DATA_WIDTH  stream data
out_last  out  1  final beat of transfer
out_ready  in  1  downstream ready
M_AXI_AR* (ARID, ARADDR, ARLEN[8], ARSIZE[3], ARBURST[2], ARLOCK, ARCACHE[4], ARPROT[3], ARQOS[4], ARUSER, ARVALID)  out  AXI4 read address
M_AXI_ARREADY  in  1
M_AXI_R* (RID, RDATA, RRESP[2], RLAST, RUSER, RVALID)  in  AXI4 read data
M_AXI_RREADY  out  1

Behaviour:
- Reset: every output 0. FIFO empty, counters cleared, state IDLE, error cleared. Reset mid-transfer abandons in-flight bursts; their later R beats are not held off and are discarded until a new start is accepted.
- Constants: ARID=0, ARSIZE=log2(DATA_WIDTH/8), ARBURST=INCR, ARCACHE=4'b0011, ARLOCK/ARPROT/ARQOS/ARUSER=0.
- FSM: IDLE -> (start) ISSUE -> (remaining==0) DRAIN -> (final beat accepted downstream) IDLE with transfer_done pulse.
- IDLE + start: latch addr and length, clear error, assert busy next cycle.
  - length==0: transfer_done pulses 1 cycle after start; no AR issued; busy stays 0.
- ISSUE: burst len L = min(remaining, C_M_AXI_BURST_LEN, (4096 - addr[11:0]) / bytes_per_beat).
  - ARVALID rises when ARVALID==0, outstanding < C_MAX_OUTSTANDING, and credits >= L.
  - First ARVALID appears no earlier than 1 cycle after start.
  - ARLEN=L-1. ARADDR/ARLEN stay stable while ARVALID=1 and ARREADY=0.
  - On AR handshake: addr += L*bytes_per_beat, remaining -= L, outstanding++, inflight += L.
- Credits = C_FIFO_DEPTH - fifo_count - inflight. Because space is reserved at issue, RREADY=1 whenever busy (also 1 in IDLE to discard stragglers) and the FIFO never overflows.
- R handshake: write RDATA into FIFO, inflight--. RLAST decrements outstanding. RRESP != 0 sets error (sticky until next start). Data is still forwarded.
- Output: first-word-fall-through. out_valid = !empty. Pop on out_valid & out_ready.
  - out_last=1 on beat number starting_length (tracked by delivered counter).
- Same-cycle AR handshake and RLAST: outstanding holds. Simultaneous FIFO push and pop: count holds.
- transfer_done pulses the cycle after the last-beat pop; busy drops the same cycle.

Test Plan:
- addr 0x1000, len 4, D=64 -> one AR ARADDR=0x1000 ARLEN=3 ARSIZE=3; 4 beats out, out_last on 4th, transfer_done 1 cycle later.
- addr 0x0FF0, len 8 -> AR 0x0FF0 ARLEN=1, then AR 0x1000 ARLEN=5; stream data in order, 8 beats.
- addr 0x0, len 600, ARREADY always 1 -> ARLEN 255, 255, 87; 600 beats; only beat 600 has out_last.
- out_ready=0, FIFO_DEPTH 512, len 1024 -> exactly 2 ARs of 256 issued then ARVALID stays low; no overflow; release out_ready -> remaining 2 bursts issue, 1024 beats delivered in order.
- RRESP=2 on beat 3 of len 8 -> error=1 from next cycle to end; all 8 beats delivered; next start clears error.
- ARESET asserted with 2 bursts in flight -> all outputs 0 the next cycle; stray R beats discarded; new start len 2 completes normally; start with len 0 -> done pulse and no AR.

Source files
------------

// File: rtl/knn_dma_mm2s_burst_engine_if.sv
// knn_dma_mm2s_burst_engine_if: AXI4 read address and read data channel bundle
interface knn_dma_mm2s_burst_engine_if #(
    parameter int ID_W     = 1,
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 64,
    parameter int ARUSER_W = 1,
    parameter int RUSER_W  = 1
);
    logic [ID_W-1:0]     ARID;
    logic [ADDR_W-1:0]   ARADDR;
    logic [7:0]          ARLEN;
    logic [2:0]          ARSIZE;
    logic [1:0]          ARBURST;
    logic                ARLOCK;
    logic [3:0]          ARCACHE;
    logic [2:0]          ARPROT;
    logic [3:0]          ARQOS;
    logic [ARUSER_W-1:0] ARUSER;
    logic                ARVALID;
    logic                ARREADY;
    logic [ID_W-1:0]     RID;
    logic [DATA_W-1:0]   RDATA;
    logic [1:0]          RRESP;
    logic                RLAST;
    logic [RUSER_W-1:0]  RUSER;
    logic                RVALID;
    logic                RREADY;

    modport master (
        output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARLOCK, ARCACHE, ARPROT, ARQOS, ARUSER, ARVALID, RREADY,
        input  ARREADY, RID, RDATA, RRESP, RLAST, RUSER, RVALID
    );

    modport slave (
        input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARLOCK, ARCACHE, ARPROT, ARQOS, ARUSER, ARVALID, RREADY,
        output ARREADY, RID, RDATA, RRESP, RLAST, RUSER, RVALID
    );
endinterface

// File: rtl/knn_dma_mm2s_burst_engine.sv
// knn_dma_mm2s_burst_engine: AXI4 MM2S read master with 4 KB-safe bursts and credit-reserved output FIFO
module knn_dma_mm2s_burst_engine #(
    parameter int C_M_AXI_BURST_LEN    = 256,
    parameter int C_M_AXI_ID_WIDTH     = 1,
    parameter int C_M_AXI_ADDR_WIDTH   = 32,
    parameter int C_M_AXI_DATA_WIDTH   = 64,
    parameter int C_M_AXI_ARUSER_WIDTH = 1,
    parameter int C_M_AXI_RUSER_WIDTH  = 1,
    parameter int C_MAX_OUTSTANDING    = 4,
    parameter int C_FIFO_DEPTH         = 512
) (
    input  logic                          M_AXI_ACLK,
    input  logic                          M_AXI_ARESET,
    input  logic                          start,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0] starting_addr,
    input  logic [31:0]                   starting_length,
    output logic                          busy,
    output logic                          transfer_done,
    output logic                          error,
    output logic                          out_valid,
    output logic [C_M_AXI_DATA_WIDTH-1:0] out_data,
    output logic                          out_last,
    input  logic                          out_ready,
    knn_dma_mm2s_burst_engine_if.master   m_axi
);
    localparam int BPB = C_M_AXI_DATA_WIDTH / 8;
    localparam int SZ  = $clog2(BPB);
    localparam int PW  = $clog2(C_FIFO_DEPTH);
    localparam int CW  = PW + 1;
    localparam int OW  = $clog2(C_MAX_OUTSTANDING + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t                          state_q;
    logic [C_M_AXI_ADDR_WIDTH-1:0]   addr_q, araddr_q;
    logic [31:0]                     remaining_q, length_q, delivered_q;
    logic [8:0]                      burst_q;
    logic [7:0]                      arlen_q;
    logic [OW-1:0]                   outstanding_q;
    logic [CW-1:0]                   inflight_q, count_q;
    logic [PW-1:0]                   wr_q, rd_q;
    logic                            arvalid_q, rready_q, busy_q, done_q, error_q;
    logic [C_M_AXI_DATA_WIDTH-1:0]   mem_q [C_FIFO_DEPTH];

    logic [12:0] to_bound;
    logic [31:0] cap, blen, credits;
    logic        can_issue, ar_hs, r_push, pop, unused_ok;

    // Burst length is the tightest of remaining beats, max burst and beats left in the 4 KB page
    assign to_bound  = (13'd4096 - {1'b0, addr_q[11:0]}) >> SZ;
    assign cap       = (32'(to_bound) < 32'(C_M_AXI_BURST_LEN)) ? 32'(to_bound) : 32'(C_M_AXI_BURST_LEN);
    assign blen      = (remaining_q < cap) ? remaining_q : cap;
    assign credits   = 32'(C_FIFO_DEPTH) - 32'(count_q) - 32'(inflight_q);
    assign can_issue = (state_q == ISSUE) && !arvalid_q && (remaining_q != 0) &&
                       (32'(outstanding_q) < 32'(C_MAX_OUTSTANDING)) && (credits >= blen);
    assign ar_hs     = arvalid_q && m_axi.ARREADY;
    assign r_push    = m_axi.RVALID && rready_q && (state_q != IDLE);
    assign out_valid = count_q != 0;
    assign pop       = out_valid && out_ready;
    assign out_last  = out_valid && (delivered_q == length_q - 32'd1);
    assign out_data  = out_valid ? mem_q[rd_q] : '0;
    assign unused_ok = ^{m_axi.RID, m_axi.RUSER};

    assign busy          = busy_q;
    assign transfer_done = done_q;
    assign error         = error_q;

    assign m_axi.ARID    = '0;
    assign m_axi.ARADDR  = araddr_q;
    assign m_axi.ARLEN   = arlen_q;
    assign m_axi.ARSIZE  = 3'(SZ);
    assign m_axi.ARBURST = 2'b01;
    assign m_axi.ARLOCK  = 1'b0;
    assign m_axi.ARCACHE = 4'b0011;
    assign m_axi.ARPROT  = '0;
    assign m_axi.ARQOS   = '0;
    assign m_axi.ARUSER  = '0;
    assign m_axi.ARVALID = arvalid_q;
    assign m_axi.RREADY  = rready_q;

    // FIFO storage: space for every pushed beat was reserved when its burst was issued
    always_ff @(posedge M_AXI_ACLK) begin
        if (r_push) mem_q[wr_q] <= m_axi.RDATA;
    end

    // Control FSM, burst issue, in-flight accounting and registered outputs
    always_ff @(posedge M_AXI_ACLK) begin
        if (M_AXI_ARESET) begin
            state_q       <= IDLE;
            addr_q        <= '0;
            araddr_q      <= '0;
            remaining_q   <= '0;
            length_q      <= '0;
            delivered_q   <= '0;
            burst_q       <= '0;
            arlen_q       <= '0;
            outstanding_q <= '0;
            inflight_q    <= '0;
            count_q       <= '0;
            wr_q          <= '0;
            rd_q          <= '0;
            arvalid_q     <= 1'b0;
            rready_q      <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            error_q       <= 1'b0;
        end else begin
            done_q        <= 1'b0;
            rready_q      <= 1'b1;
            count_q       <= count_q + CW'(r_push) - CW'(pop);
            wr_q          <= wr_q + PW'(r_push);
            rd_q          <= rd_q + PW'(pop);
            delivered_q   <= delivered_q + 32'(pop);
            outstanding_q <= outstanding_q + OW'(ar_hs) - OW'(r_push && m_axi.RLAST);
            inflight_q    <= inflight_q + (ar_hs ? CW'(burst_q) : CW'(0)) - CW'(r_push);
            if (r_push && m_axi.RRESP != 2'b00) error_q <= 1'b1;
            if (can_issue) begin
                arvalid_q <= 1'b1;
                araddr_q  <= addr_q;
                arlen_q   <= 8'(blen - 32'd1);
                burst_q   <= 9'(blen);
            end
            if (ar_hs) begin
                arvalid_q   <= 1'b0;
                addr_q      <= addr_q + (C_M_AXI_ADDR_WIDTH'(burst_q) << SZ);
                remaining_q <= remaining_q - 32'(burst_q);
            end
            case (state_q)
                IDLE: if (start) begin
                    addr_q      <= {starting_addr[C_M_AXI_ADDR_WIDTH-1:SZ], SZ'(0)};
                    length_q    <= starting_length;
                    remaining_q <= starting_length;
                    delivered_q <= '0;
                    error_q     <= 1'b0;
                    if (starting_length == 0) done_q <= 1'b1;
                    else begin
                        state_q <= ISSUE;
                        busy_q  <= 1'b1;
                    end
                end
                ISSUE: if (remaining_q == 0 && !arvalid_q) state_q <= DRAIN;
                default: ;
            endcase
            if (pop && out_last) begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_knn_dma_mm2s_burst_engine.sv
// tb_knn_dma_mm2s_burst_engine: randomized AXI slave + stream sink checked against a transfer-level model
module tb_knn_dma_mm2s_burst_engine;
    localparam int MAXO = 4;
    localparam int DEPTH = 512;

    typedef struct {
        logic [31:0] a;
        int          l;
    } burst_t;

    logic        clk = 1'b0, rst = 1'b1, start = 1'b0, out_ready = 1'b0;
    logic [31:0] saddr = '0, slen = '0;
    logic        busy, transfer_done, error, out_valid, out_last;
    logic [63:0] out_data;

    knn_dma_mm2s_burst_engine_if #(.ID_W(1), .ADDR_W(32), .DATA_W(64), .ARUSER_W(1), .RUSER_W(1)) axi ();

    knn_dma_mm2s_burst_engine #(
        .C_M_AXI_BURST_LEN(256), .C_M_AXI_ID_WIDTH(1), .C_M_AXI_ADDR_WIDTH(32), .C_M_AXI_DATA_WIDTH(64),
        .C_M_AXI_ARUSER_WIDTH(1), .C_M_AXI_RUSER_WIDTH(1), .C_MAX_OUTSTANDING(MAXO), .C_FIFO_DEPTH(DEPTH)
    ) dut (
        .M_AXI_ACLK(clk), .M_AXI_ARESET(rst), .start(start), .starting_addr(saddr), .starting_length(slen),
        .busy(busy), .transfer_done(transfer_done), .error(error), .out_valid(out_valid), .out_data(out_data),
        .out_last(out_last), .out_ready(out_ready), .m_axi(axi)
    );

    // Free-running clock
    always #5 clk = ~clk;

    int cyc = 0;
    // Cycle counter used to time-stamp observed events
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0, n_fail = 0;
    int ar_p = 100, rv_p = 100, or_p = 100, err_beat = -1, beat_g = 0, r_idx = 0;
    int occ = 0, max_occ = 0, max_out = 0, stab_viol = 0, hdr_bad = 0;
    int done_cnt = 0, done_cyc = -1, last_cyc = -1, err_first = -1, bad_cyc = -1;
    logic busy_at_done = 1'b0, err_at_done = 1'b0;
    logic [63:0] seed = 64'h0;
    burst_t ar_q[$], ar_log[$];
    logic [64:0] out_log[$];

    function automatic logic [63:0] mw(input logic [31:0] a);
        return {a ^ seed[31:0], ~a ^ seed[63:32]};
    endfunction

    // AXI slave memory, stream sink and bus monitor: sample at negedge, drive just after posedge
    initial begin
        logic ar_hs, r_hs, pop_hs, pend;
        logic [31:0] pa;
        logic [7:0] pl;
        burst_t nb;
        pend = 1'b0; pa = '0; pl = '0; nb.a = '0; nb.l = 0;
        axi.ARREADY = 1'b0; axi.RVALID = 1'b0; axi.RDATA = '0; axi.RRESP = '0;
        axi.RLAST = 1'b0; axi.RID = '0; axi.RUSER = '0;
        forever begin
            @(negedge clk);
            ar_hs = axi.ARVALID && axi.ARREADY;
            r_hs = axi.RVALID && axi.RREADY;
            pop_hs = out_valid && out_ready;
            if (pend && axi.ARVALID && (axi.ARADDR !== pa || axi.ARLEN !== pl)) stab_viol++;
            pend = !rst && axi.ARVALID && !axi.ARREADY;
            pa = axi.ARADDR;
            pl = axi.ARLEN;
            if (ar_hs) begin
                nb.a = axi.ARADDR;
                nb.l = int'(axi.ARLEN) + 1;
                ar_log.push_back(nb);
                if (axi.ARSIZE !== 3'd3 || axi.ARBURST !== 2'b01 || axi.ARCACHE !== 4'b0011 || axi.ARID !== 1'b0 ||
                    axi.ARLOCK !== 1'b0 || axi.ARPROT !== 3'd0 || axi.ARQOS !== 4'd0 || axi.ARUSER !== 1'b0) hdr_bad++;
            end
            if (rst) occ = 0;
            else begin
                if (r_hs && busy) occ++;
                if (pop_hs) begin
                    occ--;
                    out_log.push_back({out_last, out_data});
                    if (out_last) last_cyc = cyc;
                end
                if (occ > max_occ) max_occ = occ;
                if (r_hs && busy && axi.RRESP != 2'b00 && bad_cyc < 0) bad_cyc = cyc;
                if (error && err_first < 0) err_first = cyc;
                if (transfer_done) begin
                    done_cnt++;
                    done_cyc = cyc;
                    busy_at_done = busy;
                    err_at_done = error;
                end
            end
            @(posedge clk);
            #1;
            if (r_hs) begin
                beat_g++;
                r_idx++;
                if (r_idx == ar_q[0].l) begin
                    void'(ar_q.pop_front());
                    r_idx = 0;
                end
            end
            if (ar_hs) ar_q.push_back(nb);
            if (ar_q.size() > max_out) max_out = ar_q.size();
            axi.ARREADY = int'($urandom_range(99)) < ar_p;
            if (!(axi.RVALID && !r_hs)) axi.RVALID = (ar_q.size() != 0) && (int'($urandom_range(99)) < rv_p);
            if (ar_q.size() != 0) begin
                axi.RDATA = mw(ar_q[0].a + 32'(r_idx * 8));
                axi.RLAST = (r_idx == ar_q[0].l - 1);
                axi.RRESP = (beat_g == err_beat) ? 2'd2 : 2'd0;
            end
            out_ready = int'($urandom_range(99)) < or_p;
        end
    end

    task automatic kick(input logic [31:0] a, input int len, input int ep);
        @(negedge clk);
        #2;
        ar_log.delete(); out_log.delete();
        done_cnt = 0; max_occ = 0; max_out = 0; stab_viol = 0; hdr_bad = 0;
        beat_g = 0; err_beat = ep; last_cyc = -1; done_cyc = -1;
        @(posedge clk);
        #1;
        start = 1'b1; saddr = a; slen = len;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        #2;
        n_checks++;
        if (busy !== (len != 0) || error !== 1'b0 || transfer_done !== (len == 0)) begin
            n_fail++;
            $display("FAIL start_response: busy/error/done = %b%b%b, need %b0%b", busy, error, transfer_done, len != 0, len == 0);
        end
        err_first = -1;
        bad_cyc = -1;
    endtask

    task automatic wait_done(input int budget, input string nm);
        int n = 0;
        while (done_cnt == 0 && n < budget) begin
            @(negedge clk);
            #2;
            n++;
        end
        repeat (2) @(negedge clk);
        #2;
        n_checks++;
        if (done_cnt != 1) begin
            n_fail++;
            $display("FAIL %s_done_count: saw %0d transfer_done pulses, need 1", nm, done_cnt);
        end
    endtask

    task automatic check_xfer(input string nm, input logic [31:0] a, input int len, input int ep);
        burst_t exp[$];
        burst_t b;
        logic [31:0] x;
        logic [64:0] e;
        int rem, l, room, n;
        x = a & ~32'h7;
        rem = len;
        while (rem > 0) begin
            room = (4096 - int'(x % 4096)) / 8;
            l = rem;
            if (l > 256) l = 256;
            if (l > room) l = room;
            b.a = x;
            b.l = l;
            exp.push_back(b);
            x += 32'(l * 8);
            rem -= l;
        end
        n_checks++;
        if (ar_log.size() != exp.size()) begin
            n_fail++;
            $display("FAIL %s_ar_count: got %0d bursts, need %0d", nm, ar_log.size(), exp.size());
        end
        n = (ar_log.size() < exp.size()) ? ar_log.size() : exp.size();
        for (int i = 0; i < n; i++) begin
            n_checks++;
            if (ar_log[i].a !== exp[i].a || ar_log[i].l != exp[i].l) begin
                n_fail++;
                $display("FAIL %s_ar%0d: got addr %h beats %0d, need addr %h beats %0d", nm, i, ar_log[i].a, ar_log[i].l, exp[i].a, exp[i].l);
            end
        end
        n_checks++;
        if (out_log.size() != len) begin
            n_fail++;
            $display("FAIL %s_beat_count: got %0d beats, need %0d", nm, out_log.size(), len);
        end
        n = (out_log.size() < len) ? out_log.size() : len;
        for (int i = 0; i < n; i++) begin
            e = {i == len - 1, mw((a & ~32'h7) + 32'(i * 8))};
            n_checks++;
            if (out_log[i] !== e) begin
                n_fail++;
                $display("FAIL %s_beat%0d: got last/data %h, need %h", nm, i, out_log[i], e);
            end
        end
        n_checks++;
        if (done_cyc != last_cyc + 1 || busy_at_done !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_done_timing: done at %0d busy %b, last beat at %0d, need done at last+1 with busy 0", nm, done_cyc, busy_at_done, last_cyc);
        end
        n_checks++;
        if (ep >= 0 && ep < len) begin
            if (err_at_done !== 1'b1 || err_first != bad_cyc + 1) begin
                n_fail++;
                $display("FAIL %s_error: rose at %0d, at done %b, need rise at %0d and 1 at done", nm, err_first, err_at_done, bad_cyc + 1);
            end
        end else if (err_first != -1) begin
            n_fail++;
            $display("FAIL %s_error: rose at cycle %0d, need never", nm, err_first);
        end
        n_checks++;
        if (max_out > MAXO || max_occ > DEPTH || stab_viol != 0 || hdr_bad != 0) begin
            n_fail++;
            $display("FAIL %s_limits: outstanding %0d fifo %0d unstable %0d badhdr %0d, need <=%0d <=%0d 0 0", nm, max_out, max_occ, stab_viol, hdr_bad, MAXO, DEPTH);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #2;
        n_checks++;
        if ({busy, transfer_done, error, out_valid, out_last, axi.ARVALID, axi.RREADY} !== 7'b0 ||
            out_data !== 64'h0 || axi.ARADDR !== 32'h0 || axi.ARLEN !== 8'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: flags %b addr %h len %h data %h, need all 0",
                     {busy, transfer_done, error, out_valid, out_last, axi.ARVALID, axi.RREADY}, axi.ARADDR, axi.ARLEN, out_data);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2;
        n_checks++;
        if (axi.RREADY !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_rready: RREADY %b busy %b, need 1 0", axi.RREADY, busy);
        end
    endtask

    task automatic test_single();
        seed = {$urandom, $urandom};
        ar_p = 100; rv_p = 100; or_p = 100;
        kick(32'h1000, 4, -1);
        wait_done(200, "single");
        check_xfer("single", 32'h1000, 4, -1);
        n_checks++;
        if (ar_log.size() < 1 || ar_log[0].a !== 32'h1000 || ar_log[0].l != 4) begin
            n_fail++;
            $display("FAIL single_ar_fixed: got %0d bursts, need one at 1000 with ARLEN 3", ar_log.size());
        end
    endtask

    task automatic test_4k_split();
        seed = {$urandom, $urandom};
        ar_p = 60; rv_p = 60; or_p = 60;
        kick(32'h0FF0, 8, -1);
        wait_done(400, "split");
        check_xfer("split", 32'h0FF0, 8, -1);
        n_checks++;
        if (ar_log.size() != 2 || ar_log[0].a !== 32'h0FF0 || ar_log[0].l != 2 || ar_log[1].a !== 32'h1000 || ar_log[1].l != 6) begin
            n_fail++;
            $display("FAIL split_ar_fixed: got %0d bursts, need 0ff0/ARLEN 1 then 1000/ARLEN 5", ar_log.size());
        end
    endtask

    task automatic test_long();
        seed = {$urandom, $urandom};
        ar_p = 100; rv_p = 100; or_p = 100;
        kick(32'h0, 600, -1);
        wait_done(3000, "long");
        check_xfer("long", 32'h0, 600, -1);
        n_checks++;
        if (ar_log.size() != 3 || ar_log[0].l != 256 || ar_log[1].l != 256 || ar_log[2].l != 88) begin
            n_fail++;
            $display("FAIL long_arlen: got %0d bursts, need ARLEN 255 255 87", ar_log.size());
        end
    endtask

    task automatic test_backpressure();
        seed = {$urandom, $urandom};
        ar_p = 100; rv_p = 100; or_p = 0;
        kick(32'h0, 1024, -1);
        repeat (1500) @(negedge clk);
        #2;
        n_checks++;
        if (ar_log.size() != 2 || axi.ARVALID !== 1'b0 || occ != DEPTH) begin
            n_fail++;
            $display("FAIL backpressure_hold: %0d bursts ARVALID %b fifo %0d, need 2 0 %0d", ar_log.size(), axi.ARVALID, occ, DEPTH);
        end
        or_p = 70;
        wait_done(10000, "backpressure");
        check_xfer("backpressure", 32'h0, 1024, -1);
    endtask

    task automatic test_error();
        seed = {$urandom, $urandom};
        ar_p = 80; rv_p = 80; or_p = 80;
        kick(32'h5008, 8, 2);
        wait_done(400, "rresp");
        check_xfer("rresp", 32'h5008, 8, 2);
        repeat (3) @(negedge clk);
        #2;
        n_checks++;
        if (error !== 1'b1) begin
            n_fail++;
            $display("FAIL error_sticky: error %b after transfer end, need 1", error);
        end
        kick(32'h2000, 3, -1);
        wait_done(400, "after_err");
        check_xfer("after_err", 32'h2000, 3, -1);
    endtask

    task automatic test_reset_midflight();
        int n = 0;
        seed = {$urandom, $urandom};
        ar_p = 100; rv_p = 40; or_p = 0;
        kick(32'h3000, 1024, -1);
        while (ar_log.size() < 2 && n < 200) begin
            @(negedge clk);
            #2;
            n++;
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #2;
        n_checks++;
        if ({busy, transfer_done, error, out_valid, out_last, axi.ARVALID, axi.RREADY} !== 7'b0 || out_data !== 64'h0) begin
            n_fail++;
            $display("FAIL midreset_outputs: flags %b data %h, need all 0",
                     {busy, transfer_done, error, out_valid, out_last, axi.ARVALID, axi.RREADY}, out_data);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        rv_p = 100; or_p = 100;
        n = 0;
        while (ar_q.size() != 0 && n < 5000) begin
            @(negedge clk);
            #2;
            n++;
        end
        n_checks++;
        if (ar_q.size() != 0 || out_valid !== 1'b0 || busy !== 1'b0 || out_log.size() != 0) begin
            n_fail++;
            $display("FAIL stray_discard: pending %0d out_valid %b busy %b popped %0d, need 0 0 0 0", ar_q.size(), out_valid, busy, out_log.size());
        end
        kick(32'h3000, 2, -1);
        wait_done(200, "post_reset");
        check_xfer("post_reset", 32'h3000, 2, -1);
        kick(32'h4000, 0, -1);
        repeat (5) @(negedge clk);
        #2;
        n_checks++;
        if (ar_log.size() != 0 || done_cnt != 1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_length: %0d bursts %0d done pulses busy %b, need 0 1 0", ar_log.size(), done_cnt, busy);
        end
    endtask

    task automatic test_random();
        logic [31:0] a;
        int len, ep;
        for (int k = 0; k < 6; k++) begin
            seed = {$urandom, $urandom};
            a = 32'($urandom_range(3)) * 32'd4096 + 32'($urandom_range(511)) * 32'd8;
            len = int'($urandom_range(700, 1));
            ep = ($urandom_range(2) == 0) ? int'($urandom_range(len - 1)) : -1;
            ar_p = int'($urandom_range(100, 30));
            rv_p = int'($urandom_range(100, 30));
            or_p = int'($urandom_range(100, 30));
            kick(a, len, ep);
            wait_done(len * 12 + 500, "random");
            check_xfer("random", a, len, ep);
        end
    endtask

    // Scenario sequence and summary
    initial begin
        test_reset();
        test_single();
        test_4k_split();
        test_long();
        test_backpressure();
        test_error();
        test_reset_midflight();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global time limit so the run always ends
    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1);
    end
endmodule
